// File: rtl/backtrack_replay.sv
// backtrack_replay: records the live steering command into a small LIFO once
// per sample tick. While backtrack_active is high it plays the recorded
// positions back newest-first, one per tick, then holds the last one.
module backtrack_replay #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 10000000,
    parameter int CENTER   = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       pos_in,
    input  logic                    backtrack_active,
    output logic [DATA_W-1:0]       pos_out,
    output logic                    replaying,
    output logic [$clog2(DEPTH):0]  level
);

    // DEPTH is a power of two, so the top pointer wraps on its own.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0]  TICK_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
    localparam logic [DATA_W-1:0] CENTER_V = DATA_W'(CENTER);

    typedef enum logic [1:0] {
        ST_RECORD,
        ST_REPLAY,
        ST_HOLD
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               prev_reg;
    logic [PTR_W-1:0]   top_reg;
    logic [LVL_W-1:0]   level_reg;
    logic [DATA_W-1:0]  pos_out_reg;
    logic               replaying_reg;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               tick;
    logic               rise;
    logic               fall;
    logic               do_push;
    logic               do_pop;
    logic [PTR_W-1:0]   pop_addr;

    assign tick     = (cnt_reg == TICK_MAX);
    assign rise     = backtrack_active & ~prev_reg;
    assign fall     = ~backtrack_active & prev_reg;
    // top_reg points at the next free slot; the newest entry sits just below it.
    assign pop_addr = top_reg - PTR_W'(1);

    // Edge detector history for backtrack_active.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= backtrack_active;
        end
    end

    // Sample tick divider; restarts on every state change so the first tick
    // in a new state comes a full period after entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if ((state_next != state_reg) || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_RECORD;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and push/pop decisions. Mode changes win over ticks,
    // so the edge that switches state never pushes or pops.
    always_comb begin
        state_next = state_reg;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        case (state_reg)
            ST_RECORD: begin
                if (rise) begin
                    state_next = ST_REPLAY;
                end else if (tick) begin
                    do_push = 1'b1;
                end
            end
            ST_REPLAY: begin
                if (fall) begin
                    state_next = ST_RECORD;
                end else if (level_reg == '0) begin
                    state_next = ST_HOLD;
                end else if (tick) begin
                    do_pop = 1'b1;
                    if (level_reg == LVL_ONE) begin
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (fall) begin
                    state_next = ST_RECORD;
                end
            end
            default: begin
                state_next = ST_RECORD;
            end
        endcase
    end

    // History storage write port; contents survive reset, only the
    // pointer and level are cleared.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[top_reg] <= pos_in;
        end
    end

    // Top pointer and fill level; a push into a full buffer overwrites the
    // oldest entry and leaves the level saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_reg   <= '0;
            level_reg <= '0;
        end else if (do_push) begin
            top_reg <= top_reg + PTR_W'(1);
            if (level_reg != LVL_FULL) begin
                level_reg <= level_reg + LVL_ONE;
            end
        end else if (do_pop) begin
            top_reg   <= pop_addr;
            level_reg <= level_reg - LVL_ONE;
        end
    end

    // Servo command register: tracks the live input while recording, takes
    // the popped entry on a replay tick, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_out_reg <= CENTER_V;
        end else if (state_reg == ST_RECORD) begin
            pos_out_reg <= pos_in;
        end else if (do_pop) begin
            pos_out_reg <= mem[pop_addr];
        end
    end

    // Replay status flag, updated alongside the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            replaying_reg <= 1'b0;
        end else begin
            replaying_reg <= (state_next != ST_RECORD);
        end
    end

    assign pos_out   = pos_out_reg;
    assign replaying = replaying_reg;
    assign level     = level_reg;

endmodule

// File: doc/backtrack_replay.md
BACKTRACK_REPLAY -- requirements
Module: backtrack_replay

Interface
REQ-001 SHALL have parameter: DATA_W, 8, servo position width in bits.
REQ-002 SHALL have parameter: DEPTH, 16, history entries (power of two).
REQ-003 SHALL have parameter: TICK_DIV, 10000000, clk cycles per sample tick (100 ms at 100 MHz).
REQ-004 SHALL have parameter: CENTER, 128, servo neutral position.
REQ-005 SHALL have port: clk  input  1  single system clock; all logic on posedge.
REQ-006 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port: pos_in  input  DATA_W  live steering command from the SPI path.
REQ-008 SHALL have port: backtrack_active  input  1  level from the 5 s bumper timer; high = reverse the recorded path.
REQ-009 SHALL have port: pos_out  output  DATA_W  registered command to the servo PWM stage.
REQ-010 SHALL have port: replaying  output  1  high while in REPLAY or HOLD.
REQ-011 SHALL have port: level  output  log2(DEPTH)+1  current number of stored entries.

Function
REQ-012 SHALL run a free tick counter 0..TICK_DIV-1; tick asserts for one cycle when count = TICK_DIV-1, then wraps to 0.
REQ-013 SHALL clear the tick counter to 0 on every state change, so the first tick falls TICK_DIV cycles after entry.
REQ-014 SHALL register backtrack_active once (prev flag); rise = active & !prev, fall = !active & prev.
REQ-015 SHALL implement states RECORD, REPLAY, HOLD; reset state RECORD.
REQ-016 RECORD: pos_out <= pos_in every cycle (1-cycle latency); on tick, push pos_in to the LIFO.
REQ-017 Push when level = DEPTH SHALL overwrite the oldest entry (circular buffer, top pointer wraps mod DEPTH); level stays DEPTH.
REQ-018 RECORD -> REPLAY on rise; that cycle SHALL NOT push even if tick coincides.
REQ-019 REPLAY: on tick with level > 0, pop newest entry; pos_out <= popped value next cycle; level decrements.
REQ-020 REPLAY: between ticks, pos_out SHALL hold its last value (last live pos_in on entry).
REQ-021 REPLAY -> HOLD when a pop leaves level = 0, or on entry with level = 0 (immediately, next cycle).
REQ-022 HOLD: pos_out SHALL hold its last value; no push, no pop.
REQ-023 REPLAY or HOLD -> RECORD on fall; remaining entries SHALL be retained, no pop on that cycle even if tick coincides.
REQ-024 Fall and rise in consecutive cycles SHALL each be honoured in order; pulses shorter than one clock are not required to be seen.
REQ-025 replaying SHALL be high exactly when state is REPLAY or HOLD, registered with the state.
REQ-026 level SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-027 On rst high at a clock edge: state RECORD, level 0, top pointer 0, tick counter 0, prev flag 0, pos_out CENTER, replaying 0.
REQ-028 rst SHALL take priority over every other event, including mid-REPLAY; storage contents need not be cleared.
REQ-029 After rst release, pos_out SHALL remain CENTER until the first cycle of pos_in sampling (next edge).

Verification (TICK_DIV = 4, DEPTH = 4)
REQ-030 Reset then pos_in = 10,20,30 across three ticks, backtrack high -> replaying 1, pos_out 30, 20, 10 on successive ticks, then HOLD at 10, level 0.
REQ-031 Six ticks pushing 1..6 -> level 4; replay yields 6,5,4,3 then HOLD at 3 (entries 1,2 overwritten).
REQ-032 backtrack rise on same cycle as tick -> no push; level unchanged; first pop TICK_DIV cycles later.
REQ-033 Replay of 4 entries interrupted by fall after 2 pops -> RECORD, level 2, pos_out tracks pos_in next cycle, replaying 0.
REQ-034 Rise with level 0 -> HOLD next cycle, pos_out keeps last live pos_in.
REQ-035 rst asserted mid-REPLAY -> next cycle pos_out 128, level 0, replaying 0, state RECORD.
